// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO (rdclk domain).
// Derives empty, level and almost-empty from the synchronized Gray write pointer.
// Issues 1-cycle-latency memory reads into a 2-entry first-word-fall-through buffer.
// Publishes the registered Gray read pointer for the read-to-write synchronizer.
module fifo_rd_ctrl #(
  parameter int Addr_Width   = 8,
  parameter int Data_Width   = 8,
  parameter int Almost_Empty = 2
) (
  input  logic                  rdclk,
  input  logic                  rd_rst,
  input  logic [Addr_Width:0]   wptr_sync,
  input  logic [Data_Width-1:0] mem_rdata,
  input  logic                  rd_ready,
  output logic                  rd_en,
  output logic [Addr_Width-1:0] raddr,
  output logic [Addr_Width:0]   rptr,
  output logic [Data_Width-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_empty,
  output logic [Addr_Width:0]   rd_level,
  output logic                  rd_almost_empty
);

  localparam int PW = Addr_Width + 1;
  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t AE_LVL = PW'(Almost_Empty);

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Pointer state: binary read count plus its registered Gray image.
  ptr_t                  rbin_q, rbin_d;
  ptr_t                  rptr_q, rptr_d;
  // pend_q: a memory read was issued last cycle, its data arrives now.
  logic                  pend_q, pend_d;
  // Output buffer: hd_q is the head (rd_data), tl_q the second entry.
  logic [1:0]            cnt_q, cnt_d;
  logic [Data_Width-1:0] hd_q, hd_d;
  logic [Data_Width-1:0] tl_q, tl_d;

  ptr_t       wbin;
  ptr_t       rbin_inc;
  logic       mem_empty;
  logic       fire;
  logic [2:0] occ;

  // Flow control: read only while memory holds words and the buffer
  // (counting the word in flight and this cycle's pop) has room.
  always_comb begin
    wbin      = gray2bin(wptr_sync);
    rbin_inc  = rbin_q + ptr_t'(1);
    mem_empty = (rptr_q == wptr_sync);
    fire      = rd_valid & rd_ready;
    occ       = {1'b0, cnt_q} + {2'b00, pend_q} - {2'b00, fire};
    rd_en     = !rd_rst && !mem_empty && (occ < 3'd2);
  end

  // Next state for pointers and the 2-entry buffer (push at tail, pop at head).
  always_comb begin
    rbin_d = rbin_q;
    rptr_d = rptr_q;
    pend_d = rd_en;
    cnt_d  = cnt_q;
    hd_d   = hd_q;
    tl_d   = tl_q;
    if (rd_en) begin
      rbin_d = rbin_inc;
      rptr_d = bin2gray(rbin_inc);
    end
    case ({pend_q, fire})
      2'b10: begin
        if (cnt_q == 2'd0) hd_d = mem_rdata;
        else               tl_d = mem_rdata;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        hd_d  = tl_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        // Pop and push together: count unchanged, next word moves up.
        if (cnt_q == 2'd1) begin
          hd_d = mem_rdata;
        end else begin
          hd_d = tl_q;
          tl_d = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  // State registers; reset also drops any read still in flight.
  always_ff @(posedge rdclk or posedge rd_rst) begin
    if (rd_rst) begin
      rbin_q <= '0;
      rptr_q <= '0;
      pend_q <= 1'b0;
      cnt_q  <= 2'd0;
      hd_q   <= '0;
      tl_q   <= '0;
    end else begin
      rbin_q <= rbin_d;
      rptr_q <= rptr_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      hd_q   <= hd_d;
      tl_q   <= tl_d;
    end
  end

  // Outputs; level counts unread memory words, the word in flight and buffered words.
  always_comb begin
    raddr           = rbin_q[Addr_Width-1:0];
    rptr            = rptr_q;
    rd_data         = hd_q;
    rd_valid        = (cnt_q != 2'd0);
    rd_empty        = (cnt_q == 2'd0);
    rd_level        = (wbin - rbin_q) + PW'(pend_q) + PW'(cnt_q);
    rd_almost_empty = (rd_level <= AE_LVL);
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl (depth 8): reset, single word, backpressure,
// throughput/threshold, async reset mid-stream and pointer wrap.
module tb_fifo_rd_ctrl;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int PW = AW + 1;

  logic          rdclk     = 1'b0;
  logic          rd_rst    = 1'b1;
  logic [PW-1:0] wptr_sync = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          rd_ready  = 1'b0;
  logic          rd_en;
  logic [AW-1:0] raddr;
  logic [PW-1:0] rptr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_empty;
  logic [PW-1:0] rd_level;
  logic          rd_almost_empty;

  logic [DW-1:0] mem [0:7];
  logic [PW-1:0] wb = '0;
  int total = 0, bad = 0, nrd = 0, nfire = 0;
  logic viol = 1'b0;

  fifo_rd_ctrl #(.Addr_Width(AW), .Data_Width(DW), .Almost_Empty(2)) dut (
    .rdclk(rdclk), .rd_rst(rd_rst), .wptr_sync(wptr_sync), .mem_rdata(mem_rdata),
    .rd_ready(rd_ready), .rd_en(rd_en), .raddr(raddr), .rptr(rptr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_empty(rd_empty),
    .rd_level(rd_level), .rd_almost_empty(rd_almost_empty)
  );

  always #5 rdclk = ~rdclk;

  // Dual-port memory read port: data one cycle after rd_en.
  always @(posedge rdclk) if (rd_en) mem_rdata <= mem[raddr];

  function automatic logic [PW-1:0] g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Record this cycle's read/pop, then advance to the next falling edge.
  task automatic step();
    if (!rd_rst) begin
      if (rd_en) nrd++;
      if (rd_valid && rd_ready) nfire++;
      if (dut.pend_q && dut.cnt_q == 2'd2 && !(rd_valid && rd_ready)) viol = 1'b1;
    end
    @(negedge rdclk);
  endtask

  // Write side: store a word and publish the advanced Gray write pointer.
  task automatic push(input logic [DW-1:0] d);
    mem[wb[AW-1:0]] = d;
    wb = wb + 4'd1;
    wptr_sync = g(wb);
  endtask

  initial begin
    int n0, f0, wr, e, n;
    logic [4:0] en_exp;
    en_exp = 5'b00111;

    // Reset values
    @(negedge rdclk); #1;
    chk("rst_vld", rd_valid, 0);
    chk("rst_empty", rd_empty, 1);
    chk("rst_en", rd_en, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_lvl", rd_level, 0);
    chk("rst_ae", rd_almost_empty, 1);
    chk("rst_rptr", rptr, 0);
    chk("rst_raddr", raddr, 0);
    step();
    rd_rst = 1'b0; #1;
    chk("rel_en", rd_en, 0);
    step();

    // Single word: read in cycle N, rptr after N+1, valid after N+2
    push(8'hA5); #1;
    chk("s1_en", rd_en, 1);
    chk("s1_raddr", raddr, 0);
    chk("s1_lvl", rd_level, 1);
    chk("s1_ae", rd_almost_empty, 1);
    step(); #1;
    chk("s1_rptr", rptr, 1);
    chk("s1_en2", rd_en, 0);
    chk("s1_vld0", rd_valid, 0);
    chk("s1_lvl2", rd_level, 1);
    step(); #1;
    chk("s1_vld", rd_valid, 1);
    chk("s1_data", rd_data, 8'hA5);
    chk("s1_lvl3", rd_level, 1);
    chk("s1_ae3", rd_almost_empty, 1);
    step();
    rd_ready = 1'b1; #1;
    chk("s1_vld4", rd_valid, 1);
    step();
    rd_ready = 1'b0; #1;
    chk("s1_empty", rd_empty, 1);
    chk("s1_lvl0", rd_level, 0);
    step();

    // Backpressure: 5 words, consumer stalled, only 2 reads issued
    n0 = nrd;
    for (int i = 0; i < 5; i++) begin
      push(DW'(32'h10 + i)); #1;
      step();
    end
    repeat (3) begin #1; step(); end
    #1;
    chk("bp_reads", nrd - n0, 2);
    chk("bp_vld", rd_valid, 1);
    chk("bp_data", rd_data, 8'h10);
    chk("bp_lvl", rd_level, 5);
    chk("bp_ae", rd_almost_empty, 0);
    step(); #1;
    chk("bp_hold", rd_data, 8'h10);
    step();
    for (int k = 0; k < 5; k++) begin
      rd_ready = 1'b1; #1;
      chk("bp_dv", rd_valid, 1);
      chk("bp_dd", rd_data, DW'(32'h10 + k));
      chk("bp_en", rd_en, en_exp[k]);
      step();
    end
    rd_ready = 1'b0; #1;
    chk("bp_empty", rd_empty, 1);
    chk("bp_lvl0", rd_level, 0);
    chk("bp_nrd", nrd - n0, 5);
    step();

    // Throughput: fill to 8, then 16 words streamed with no bubbles
    for (int i = 0; i < 8; i++) begin
      push(DW'(32'h20 + i)); #1;
      step();
    end
    repeat (2) begin #1; step(); end
    #1;
    chk("tp_full_lvl", rd_level, 8);
    chk("tp_full_ae", rd_almost_empty, 0);
    step();
    f0 = nfire;
    wr = 8;
    rd_ready = 1'b1;
    for (int c = 0; c < 40 && (nfire - f0) < 16; c++) begin
      if (wr < 16 && (wr - (nfire - f0)) < 8) begin
        push(DW'(32'h20 + wr));
        wr++;
      end
      #1;
      chk("tp_vld", rd_valid, 1);
      chk("tp_data", rd_data, DW'(32'h20 + (nfire - f0)));
      chk("tp_lvl", rd_level, wr - (nfire - f0));
      chk("tp_ae", rd_almost_empty, (wr - (nfire - f0)) <= 2);
      step();
    end
    chk("tp_cnt", nfire - f0, 16);
    rd_ready = 1'b0; #1;
    chk("tp_empty", rd_empty, 1);
    step();

    // Async reset mid-stream with a read in flight
    for (int i = 0; i < 4; i++) begin
      push(DW'(32'h30 + i)); #1;
      step();
    end
    repeat (2) begin #1; step(); end
    rd_ready = 1'b1; #1;
    step();
    #2;
    rd_rst = 1'b1; wptr_sync = '0; wb = '0; rd_ready = 1'b0;
    #1;
    chk("rr_vld", rd_valid, 0);
    chk("rr_empty", rd_empty, 1);
    chk("rr_en", rd_en, 0);
    chk("rr_data", rd_data, 0);
    chk("rr_lvl", rd_level, 0);
    chk("rr_ae", rd_almost_empty, 1);
    chk("rr_rptr", rptr, 0);
    @(negedge rdclk);
    rd_rst = 1'b0; #1;
    chk("rr_en2", rd_en, 0);
    step(); #1;
    chk("rr_vld2", rd_valid, 0);
    chk("rr_rptr2", rptr, 0);
    step();

    // Wrap: 20 words in bursts of 8, 8, 4 from a clean pointer
    n0 = nrd;
    e = 0;
    for (int b = 0; b < 3; b++) begin
      n = (b == 2) ? 4 : 8;
      for (int i = 0; i < n; i++) begin
        push(DW'(32'h40 + e + i)); #1;
        step();
      end
      repeat (2) begin #1; step(); end
      #1;
      chk("wr_lvl", rd_level, n);
      step();
      rd_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
        #1;
        chk("wr_vld", rd_valid, 1);
        chk("wr_data", rd_data, DW'(32'h40 + e + k));
        step();
      end
      rd_ready = 1'b0; #1;
      chk("wr_empty", rd_empty, 1);
      chk("wr_rptr", rptr, g(PW'(e + n)));
      step();
      e = e + n;
    end
    chk("wr_nrd", nrd - n0, 20);

    chk("nofull", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
